// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared record type, wildcard constant and FSM states for the trace checker
package trace_pkg;

  // Also the check-sync stall poison value, so poisoned fields never fail a compare.
  localparam logic [31:0] TRACE_WILDCARD = 32'hDEADBEEF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic [31:0] addr;
  } trace_rec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } trace_state_e;

  function automatic logic field_match(input logic [31:0] exp_f, input logic [31:0] obs_f);
    return (exp_f == TRACE_WILDCARD) || (exp_f == obs_f);
  endfunction

endpackage

// File: rtl/trace_checker_if.sv
// rtl/trace_checker_if.sv - expected-record push port and observed check stream
interface trace_checker_if;
  logic        exp_valid;
  logic        exp_ready;
  logic [31:0] exp_pc;
  logic [31:0] exp_data;
  logic [31:0] exp_addr;
  logic        check_en;
  logic [31:0] check_pc;
  logic [31:0] check_data;
  logic [31:0] check_addr;

  modport master (
    output exp_valid, exp_pc, exp_data, exp_addr,
    output check_en, check_pc, check_data, check_addr,
    input  exp_ready
  );

  modport slave (
    input  exp_valid, exp_pc, exp_data, exp_addr,
    input  check_en, check_pc, check_data, check_addr,
    output exp_ready
  );
endinterface

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous FIFO of trace records; wrap-bit pointers give full/empty
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  trace_rec_t din,
  output logic       full,
  input  logic       pop,
  output trace_rec_t dout,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  trace_rec_t    mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          push_ok, pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/trace_checker.sv
// rtl/trace_checker.sv - compares observed check records against an expected trace FIFO
// Optional TRACE_CHECKER_DISPLAY_EN prints each mismatch and a summary on entry to FAIL.
module trace_checker
  import trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int MAX_ERR = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  trace_checker_if.slave        tif,
  output logic                  mismatch,
  output logic [15:0]           err_count,
  output logic [31:0]           match_count,
  output logic [31:0]           first_err_pc,
  output logic [31:0]           first_err_exp_pc,
  output logic                  underflow,
  output logic                  fail,
  output logic                  active
);

  localparam logic [16:0] MAX_ERR_W = 17'(MAX_ERR);

  trace_state_e state_q, state_d;
  logic         mismatch_q, mismatch_d;
  logic [15:0]  err_count_q, err_count_d;
  logic [31:0]  match_count_q, match_count_d;
  logic [31:0]  first_err_pc_q, first_err_pc_d;
  logic [31:0]  first_err_exp_pc_q, first_err_exp_pc_d;
  logic         underflow_q, underflow_d;
  logic         fail_q, fail_d;
  logic         active_q, active_d;

  trace_rec_t   obs_rec, head_rec, push_rec;
  logic         fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic         cmp_en, rec_ok, bad, good;
  logic [16:0]  err_next_w;

  assign push_rec      = '{pc: tif.exp_pc, data: tif.exp_data, addr: tif.exp_addr};
  assign obs_rec       = '{pc: tif.check_pc, data: tif.check_data, addr: tif.check_addr};
  assign tif.exp_ready = !fifo_full;
  assign fifo_push     = tif.exp_valid && !fifo_full;

  // FAIL freezes comparison entirely: no pop, no counter movement.
  assign cmp_en   = tif.check_en && (state_q != FAIL);
  assign fifo_pop = cmp_en && !fifo_empty;
  assign rec_ok   = !fifo_empty
                 && (head_rec.pc == obs_rec.pc)
                 && field_match(head_rec.data, obs_rec.data)
                 && field_match(head_rec.addr, obs_rec.addr);
  assign bad        = cmp_en && !rec_ok;
  assign good       = cmp_en && rec_ok;
  assign err_next_w = {1'b0, err_count_q} + 17'd1;

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (push_rec),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .dout  (head_rec),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d            = state_q;
    mismatch_d         = bad;
    err_count_d        = err_count_q;
    match_count_d      = match_count_q;
    first_err_pc_d     = first_err_pc_q;
    first_err_exp_pc_d = first_err_exp_pc_q;
    underflow_d        = underflow_q || (cmp_en && fifo_empty);
    fail_d             = (state_q == FAIL);
    active_d           = (state_q == RUN);

    if (bad && err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
    if (good) match_count_d = match_count_q + 32'd1;

    if (bad && err_count_q == 16'd0) begin
      first_err_pc_d     = obs_rec.pc;
      first_err_exp_pc_d = fifo_empty ? 32'd0 : head_rec.pc;
    end

    // Entering FAIL on the same edge as the final error makes the next check_en ignored.
    case (state_q)
      IDLE, RUN: begin
        if (bad && err_next_w >= MAX_ERR_W) state_d = FAIL;
        else if (tif.check_en)              state_d = RUN;
      end
      default: state_d = FAIL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      mismatch_q         <= 1'b0;
      err_count_q        <= '0;
      match_count_q      <= '0;
      first_err_pc_q     <= '0;
      first_err_exp_pc_q <= '0;
      underflow_q        <= 1'b0;
      fail_q             <= 1'b0;
      active_q           <= 1'b0;
    end else begin
      state_q            <= state_d;
      mismatch_q         <= mismatch_d;
      err_count_q        <= err_count_d;
      match_count_q      <= match_count_d;
      first_err_pc_q     <= first_err_pc_d;
      first_err_exp_pc_q <= first_err_exp_pc_d;
      underflow_q        <= underflow_d;
      fail_q             <= fail_d;
      active_q           <= active_d;
    end
  end

  assign mismatch         = mismatch_q;
  assign err_count        = err_count_q;
  assign match_count      = match_count_q;
  assign first_err_pc     = first_err_pc_q;
  assign first_err_exp_pc = first_err_exp_pc_q;
  assign underflow        = underflow_q;
  assign fail             = fail_q;
  assign active           = active_q;

`ifdef TRACE_CHECKER_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (!rst && bad)
      $display("%0t trace_checker mismatch: obs pc=%h data=%h addr=%h exp pc=%h data=%h addr=%h",
               $time, obs_rec.pc, obs_rec.data, obs_rec.addr,
               fifo_empty ? 32'd0 : head_rec.pc,
               fifo_empty ? 32'd0 : head_rec.data,
               fifo_empty ? 32'd0 : head_rec.addr);
    if (!rst && state_q != FAIL && state_d == FAIL)
      $display("%0t trace_checker stopped: match_count=%0d err_count=%0d",
               $time, match_count_d, err_count_d);
  end
`else
`endif

endmodule

// File: tb/tb_trace_checker.sv
// tb/tb_trace_checker.sv - directed self-checking bench for trace_checker (MAX_ERR 8 and 2)
module tb_trace_checker;
  localparam logic [31:0] WC = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trace_checker_if tif ();
  trace_checker_if tif2 ();

  // The MAX_ERR=2 instance sees exactly the same stimulus.
  assign tif2.exp_valid  = tif.exp_valid;
  assign tif2.exp_pc     = tif.exp_pc;
  assign tif2.exp_data   = tif.exp_data;
  assign tif2.exp_addr   = tif.exp_addr;
  assign tif2.check_en   = tif.check_en;
  assign tif2.check_pc   = tif.check_pc;
  assign tif2.check_data = tif.check_data;
  assign tif2.check_addr = tif.check_addr;

  logic        m1, uf1, f1, a1, m2, uf2, f2, a2;
  logic [15:0] e1, e2;
  logic [31:0] mc1, fp1, fe1, mc2, fp2, fe2;

  trace_checker #(.DEPTH(16), .MAX_ERR(8)) dut (
    .clk(clk), .rst(rst), .tif(tif.slave),
    .mismatch(m1), .err_count(e1), .match_count(mc1),
    .first_err_pc(fp1), .first_err_exp_pc(fe1),
    .underflow(uf1), .fail(f1), .active(a1)
  );

  trace_checker #(.DEPTH(16), .MAX_ERR(2)) dut2 (
    .clk(clk), .rst(rst), .tif(tif2.slave),
    .mismatch(m2), .err_count(e2), .match_count(mc2),
    .first_err_pc(fp2), .first_err_exp_pc(fe2),
    .underflow(uf2), .fail(f2), .active(a2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int seen_mism;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tif.exp_valid = 1'b0;
    tif.check_en  = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] data, input logic [31:0] addr);
    tif.exp_valid = 1'b1;
    tif.exp_pc    = pc;
    tif.exp_data  = data;
    tif.exp_addr  = addr;
    tick();
    tif.exp_valid = 1'b0;
  endtask

  task automatic set_obs(input logic [31:0] pc, input logic [31:0] data, input logic [31:0] addr);
    tif.check_en   = 1'b1;
    tif.check_pc   = pc;
    tif.check_data = data;
    tif.check_addr = addr;
  endtask

  initial begin
    tif.exp_pc = '0; tif.exp_data = '0; tif.exp_addr = '0;
    tif.check_pc = '0; tif.check_data = '0; tif.check_addr = '0;
    do_reset();

    check("rst_mismatch", 32'(m1), 32'd0);
    check("rst_err", 32'(e1), 32'd0);
    check("rst_match", mc1, 32'd0);
    check("rst_underflow", 32'(uf1), 32'd0);
    check("rst_fail", 32'(f1), 32'd0);
    check("rst_active", 32'(a1), 32'd0);
    check("rst_exp_ready", 32'(tif.exp_ready), 32'd1);
    check("rst_first_pc", fp1, 32'd0);

    // Four wildcard records, four back-to-back matching observations.
    for (int i = 0; i < 4; i++) push(32'(i * 4), WC, WC);
    seen_mism = 0;
    for (int i = 0; i < 4; i++) begin
      set_obs(32'(i * 4), 32'h1234_0000 + 32'(i), 32'h8000_0000 + 32'(i));
      tick();
      if (m1) seen_mism++;
    end
    tif.check_en = 1'b0;
    tick();
    if (m1) seen_mism++;
    check("a_match", mc1, 32'd4);
    check("a_err", 32'(e1), 32'd0);
    check("a_mism_seen", 32'(seen_mism), 32'd0);
    check("a_active", 32'(a1), 32'd1);

    // Data field mismatch.
    push(32'h10, 32'h55, 32'h100);
    set_obs(32'h10, 32'h56, 32'h100);
    tick();
    tif.check_en = 1'b0;
    check("b_mismatch", 32'(m1), 32'd1);
    check("b_err", 32'(e1), 32'd1);
    check("b_first_pc", fp1, 32'h10);
    check("b_first_exp", fe1, 32'h10);
    check("b_match", mc1, 32'd4);
    tick();
    check("b_mismatch_drop", 32'(m1), 32'd0);

    // Underflow with a same-cycle push that must not bypass.
    do_reset();
    tif.exp_valid = 1'b1;
    tif.exp_pc = 32'h20; tif.exp_data = WC; tif.exp_addr = WC;
    set_obs(32'h20, 32'h0, 32'h0);
    tick();
    tif.exp_valid = 1'b0;
    tif.check_en  = 1'b0;
    check("c_underflow", 32'(uf1), 32'd1);
    check("c_err", 32'(e1), 32'd1);
    check("c_mismatch", 32'(m1), 32'd1);
    check("c_first_pc", fp1, 32'h20);
    check("c_first_exp", fe1, 32'd0);
    set_obs(32'h20, 32'h0, 32'h0);
    tick();
    tif.check_en = 1'b0;
    check("c_late_match", mc1, 32'd1);
    check("c_late_mism", 32'(m1), 32'd0);

    // Two errors then three matches: dut2 (MAX_ERR=2) stops, dut keeps going.
    do_reset();
    for (int i = 0; i < 5; i++) push(32'h100 + 32'(i * 4), WC, WC);
    set_obs(32'h200, 32'h0, 32'h0); tick();
    set_obs(32'h204, 32'h0, 32'h0); tick();
    check("d_err2_at_pulse", 32'(e2), 32'd2);
    check("d_mism2_pulse", 32'(m2), 32'd1);
    check("d_fail2_not_yet", 32'(f2), 32'd0);
    set_obs(32'h108, 32'h0, 32'h0); tick();
    check("d_fail2_set", 32'(f2), 32'd1);
    set_obs(32'h10C, 32'h0, 32'h0); tick();
    set_obs(32'h110, 32'h0, 32'h0); tick();
    tif.check_en = 1'b0;
    tick();
    check("d_match2_frozen", mc2, 32'd0);
    check("d_err2_frozen", 32'(e2), 32'd2);
    check("d_active2", 32'(a2), 32'd0);
    check("d_match1", mc1, 32'd3);
    check("d_err1", 32'(e1), 32'd2);
    check("d_fail1", 32'(f1), 32'd0);
    for (int i = 0; i < 12; i++) push(32'h500 + 32'(i), WC, WC);
    check("d_ready2_15", 32'(tif2.exp_ready), 32'd1);
    push(32'h600, WC, WC);
    check("d_ready2_full", 32'(tif2.exp_ready), 32'd0);
    check("d_ready1_13", 32'(tif.exp_ready), 32'd1);

    // Full FIFO refuses a push even with a same-cycle pop.
    do_reset();
    for (int i = 0; i < 16; i++) push(32'(i * 4), WC, WC);
    check("e_full_ready", 32'(tif.exp_ready), 32'd0);
    tif.exp_valid = 1'b1;
    tif.exp_pc = 32'h999; tif.exp_data = WC; tif.exp_addr = WC;
    set_obs(32'h0, 32'h0, 32'h0);
    tick();
    tif.exp_valid = 1'b0;
    tif.check_en  = 1'b0;
    check("e_ready_after_pop", 32'(tif.exp_ready), 32'd1);
    check("e_pop_match", mc1, 32'd1);
    for (int i = 1; i < 16; i++) begin
      set_obs(32'(i * 4), 32'h0, 32'h0);
      tick();
    end
    check("e_drain_no_uf", 32'(uf1), 32'd0);
    set_obs(32'h999, 32'h0, 32'h0);
    tick();
    tif.check_en = 1'b0;
    check("e_refused_uf", 32'(uf1), 32'd1);
    check("e_match16", mc1, 32'd16);
    check("e_err", 32'(e1), 32'd1);

    // Mid-run reset with three errors outstanding.
    do_reset();
    push(32'h300, WC, WC);
    push(32'h304, WC, WC);
    set_obs(32'h400, 32'h0, 32'h0); tick();
    set_obs(32'h404, 32'h0, 32'h0); tick();
    set_obs(32'h408, 32'h0, 32'h0); tick();
    tif.check_en = 1'b0;
    check("f_err3", 32'(e1), 32'd3);
    check("f_fail1", 32'(f1), 32'd0);
    check("f_fail2", 32'(f2), 32'd1);
    push(32'h300, WC, WC);
    push(32'h304, WC, WC);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("f_err_clr", 32'(e1), 32'd0);
    check("f_match_clr", mc1, 32'd0);
    check("f_fail1_clr", 32'(f1), 32'd0);
    check("f_fail2_clr", 32'(f2), 32'd0);
    check("f_uf_clr", 32'(uf1), 32'd0);
    check("f_active_clr", 32'(a1), 32'd0);
    check("f_first_clr", fp1, 32'd0);
    check("f_ready", 32'(tif.exp_ready), 32'd1);
    set_obs(32'h300, 32'h0, 32'h0);
    tick();
    tif.check_en = 1'b0;
    check("f_flushed_uf", 32'(uf1), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
